femto_nmi_bridge: RTL
=====================

# femto_nmi_bridge

Protocol bridge between a FemtoRV32-style strobe/busy memory port and the SoC native memory interface (`nmi_if`). It sits directly downstream of the user core inside `user_core_design`. It converts one-cycle read strobes and write masks into a held `valid`/`ready` transaction on `nmi`, and stalls the core with `rbusy`/`wbusy` until the transaction completes. A bus watchdog aborts hung transactions, returns a fixed error word and records the event in a sticky error flag.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum cycles a request may wait for `nmi.ready`; 0 disables the watchdog.
- `ERR_RDATA`, default 32'hDEAD_BEEF: read data returned on a timed-out read.

Ports:
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `core_addr_i` in 32: byte address, sampled on the accept cycle.
- `core_wdata_i` in 32: write data, sampled on the accept cycle.
- `core_wmask_i` in 4: byte write mask; non-zero for one cycle means a write request.
- `core_rstrb_i` in 1: one-cycle read request strobe.
- `core_rdata_o` out 32: registered read data.
- `core_rbusy_o` out 1: read in progress.
- `core_wbusy_o` out 1: write in progress.
- `err_o` out 1: sticky timeout flag.
- `err_clr_i` in 1: clears `err_o`.
- `nmi` `nmi_if.master`: fields `valid`, `ready`, `addr[31:0]`, `wdata[31:0]`, `wstrb[3:0]`, `rdata[31:0]`.

## Operation
- FSM states: IDLE and REQ.
- IDLE:
  - A request is accepted in cycle T when `core_wmask_i != 0` (write) or `core_rstrb_i = 1` (read).
  - If both occur in the same cycle, the write wins. The read is dropped and `core_rdata_o` is unchanged.
  - On accept: latch addr, wdata and wstrb (wstrb = 0 for reads) into the `nmi` registers; set `nmi.valid`; set `rbusy` or `wbusy`; clear the watchdog counter; go to REQ.
- REQ:
  - `nmi.valid`, `addr`, `wdata` and `wstrb` are held stable.
  - On a cycle with `nmi.ready = 1`:
    - read: `core_rdata_o <= nmi.rdata`;
    - in all cases: clear `valid` and the busy flag, return to IDLE.
  - Core strobes arriving while in REQ are ignored. They produce no queueing and no error.
- Watchdog (`TIMEOUT_CYCLES > 0`):
  - The counter increments on every REQ cycle without `ready`.
  - When the counter reaches `TIMEOUT_CYCLES-1` with `ready` still low, the transaction aborts:
    - `valid` and busy drop;
    - reads load `core_rdata_o <= ERR_RDATA`;
    - `err_o <= 1`;
    - the FSM returns to IDLE.
  - The counter is 16 bits wide and saturates, so it never wraps.
  - If `ready` arrives in the same cycle as expiry, the normal completion wins and `err_o` is not set.
- `err_o`:
  - Set only by a timeout; cleared by `err_clr_i`.
  - If a set and a clear occur in the same cycle, set wins.

## Timing
- Reset values: `nmi.valid`=0, `nmi.addr`=0, `nmi.wdata`=0, `nmi.wstrb`=0, `core_rdata_o`=0, `core_rbusy_o`=0, `core_wbusy_o`=0, `err_o`=0, FSM=IDLE, counter=0.
- Reset is asynchronous. Asserting it mid-transaction drops `valid` and busy immediately. No completion is reported and `core_rdata_o` returns to 0.
- Accept at edge T: `valid` and busy are visible from cycle T+1, so the core sees busy in the first cycle after its strobe.
- Zero-wait slave (`ready` = 1 in T+1): busy is high for exactly one cycle. `core_rdata_o` is valid and busy is low in T+2.
- N wait cycles: busy is high for N+1 cycles; `valid` is high for the same N+1 cycles.
- Back-to-back: a new strobe is accepted in the cycle busy is low. Throughput is one transaction per two cycles at best.
- Timeout: `valid` is high for exactly `TIMEOUT_CYCLES` cycles, then busy drops and `err_o` rises in the same cycle.
- All outputs are registered; there is no combinational path from `nmi.ready` to a core output.

## Test plan
- Read, zero-wait:
  - Stimulus: `core_rstrb_i` pulse at addr 0x0000_1004; slave returns 0x1234_5678 with `ready` in T+1.
  - Required: `rbusy` high for 1 cycle; `wstrb`=0; `core_rdata_o`=0x1234_5678 at T+2.
- Write, 3 wait states:
  - Stimulus: wmask 4'b0011, wdata 0xAABB_CCDD, addr 0x2000.
  - Required: `valid` held for 4 cycles with stable `addr`/`wdata`/`wstrb`=0011; `wbusy` high 4 cycles; `core_rdata_o` unchanged.
- Simultaneous `core_rstrb_i` and wmask 4'b1111:
  - Required: a single write transaction only; `rbusy` stays 0.
- Timeout, `TIMEOUT_CYCLES`=8, `ready` tied 0:
  - Stimulus: read request.
  - Required: `valid` high 8 cycles; `core_rdata_o`=0xDEAD_BEEF; `err_o`=1.
  - Then pulse `err_clr_i` -> `err_o`=0.
  - `ready` arriving exactly at expiry -> normal data returned, `err_o` stays 0.
- Reset mid-REQ:
  - Stimulus: assert `rst_n_i`=0 two cycles into a wait-stated read.
  - Required: `valid`, busy and `core_rdata_o` go to 0 without a clock edge; after release, the next read completes normally.
- Strobe ignored while in REQ:
  - Stimulus: second `core_rstrb_i` pulse during a pending write.
  - Required: exactly one `nmi` transaction observed.

Source files
------------

// File: rtl/femto_nmi_bridge_if.sv
// rtl/femto_nmi_bridge_if.sv - native memory interface (nmi_if) bundle
//
// Ports (per modport):
//   master: drives valid, addr, wdata, wstrb; samples ready, rdata
//   slave : samples valid, addr, wdata, wstrb; drives ready, rdata
// wstrb == 0 marks a read; valid is held until the cycle ready is seen high.

interface nmi_if;
   logic        valid;
   logic        ready;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;

   modport master (output valid, output addr, output wdata, output wstrb,
                   input  ready, input  rdata);
   modport slave  (input  valid, input  addr, input  wdata, input  wstrb,
                   output ready, output rdata);
endinterface

// File: rtl/femto_nmi_bridge.sv
// rtl/femto_nmi_bridge.sv - strobe/busy core port to nmi valid/ready bridge with watchdog
//
// Ports:
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   core_addr_i      : byte address, sampled when a request is accepted
//   core_wdata_i     : write data, sampled when a request is accepted
//   core_wmask_i     : byte write mask, non-zero for one cycle = write request
//   core_rstrb_i     : one-cycle read request strobe
//   core_rdata_o     : registered read data (ERR_RDATA after a timed-out read)
//   core_rbusy_o     : read in progress
//   core_wbusy_o     : write in progress
//   err_o            : sticky watchdog timeout flag
//   err_clr_i        : clears err_o (a timeout in the same cycle wins)
//   nmi              : native memory interface, master side
// Parameters:
//   TIMEOUT_CYCLES   : max cycles a request may wait for ready, 0 disables
//   ERR_RDATA        : read data returned on a timed-out read

module femto_nmi_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wdata_i,
   input  logic [3:0]  core_wmask_i,
   input  logic        core_rstrb_i,
   output logic [31:0] core_rdata_o,
   output logic        core_rbusy_o,
   output logic        core_wbusy_o,
   output logic        err_o,
   input  logic        err_clr_i,
   nmi_if.master       nmi
);

   localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
   // Counter value in the last permitted REQ cycle; abort fires there if ready is low.
   localparam logic [31:0] WD_LAST = WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

   typedef enum logic {IDLE, REQ} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] wd_cnt;

   logic        accept_wr;
   logic        accept_rd;
   logic        done;
   logic        expire;

   // State register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept_wr || accept_rd) state_nxt = REQ;
         REQ:     if (done || expire)         state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Decode of the events that steer the datapath registers.
   // A write mask wins over a simultaneous read strobe; strobes in REQ are ignored.
   always_comb begin
      accept_wr = 1'b0;
      accept_rd = 1'b0;
      done      = 1'b0;
      expire    = 1'b0;
      if (state == IDLE) begin
         accept_wr = (core_wmask_i != 4'd0);
         accept_rd = core_rstrb_i && (core_wmask_i == 4'd0);
      end else begin
         done   = nmi.ready;
         // ready in the expiry cycle completes normally
         expire = WD_EN && !nmi.ready && ({16'd0, wd_cnt} == WD_LAST);
      end
   end

   // Transaction registers: everything the core and the slave see is a flop.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         nmi.valid    <= 1'b0;
         nmi.addr     <= 32'd0;
         nmi.wdata    <= 32'd0;
         nmi.wstrb    <= 4'd0;
         core_rdata_o <= 32'd0;
         core_rbusy_o <= 1'b0;
         core_wbusy_o <= 1'b0;
         wd_cnt       <= 16'd0;
      end else begin
         if (accept_wr || accept_rd) begin
            nmi.valid    <= 1'b1;
            nmi.addr     <= core_addr_i;
            nmi.wdata    <= core_wdata_i;
            nmi.wstrb    <= accept_wr ? core_wmask_i : 4'd0;
            core_rbusy_o <= accept_rd;
            core_wbusy_o <= accept_wr;
            wd_cnt       <= 16'd0;
         end else if (done || expire) begin
            nmi.valid    <= 1'b0;
            core_rbusy_o <= 1'b0;
            core_wbusy_o <= 1'b0;
            // rbusy doubles as the "current transaction is a read" flag
            if (core_rbusy_o) begin
               core_rdata_o <= done ? nmi.rdata : ERR_RDATA;
            end
         end else if ((state == REQ) && (wd_cnt != 16'hFFFF)) begin
            wd_cnt <= wd_cnt + 16'd1;
         end
      end
   end

   // Sticky timeout flag; a timeout beats a clear in the same cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_o <= 1'b0;
      end else if (expire) begin
         err_o <= 1'b1;
      end else if (err_clr_i) begin
         err_o <= 1'b0;
      end
   end

endmodule
